// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard inputs from ID/EX/MEM and the per-stage pipeline controls.
// The controller uses the master modport. The pipeline uses the slave modport.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             ld_use_i;
  logic             ex_busy_i;
  logic             redirect_i;
  logic [63:0]      redirect_pc_i;
  logic             mem_busy_i;
  logic [1:0]       ctrl_if_id_o;
  logic [1:0]       ctrl_id_ex_o;
  logic [1:0]       ctrl_ex_mem_o;
  logic [1:0]       ctrl_mem_wb_o;
  logic             pc_wen_o;
  logic             pc_redirect_o;
  logic [63:0]      pc_target_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             timeout_o;

  modport master (
    input  ld_use_i, ex_busy_i, redirect_i, redirect_pc_i, mem_busy_i,
    output ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
    output pc_wen_o, pc_redirect_o, pc_target_o, stall_cnt_o, timeout_o
  );

  modport slave (
    output ld_use_i, ex_busy_i, redirect_i, redirect_pc_i, mem_busy_i,
    input  ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
    input  pc_wen_o, pc_redirect_o, pc_target_o, stall_cnt_o, timeout_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: per-stage load/bubble/hold controls,
// PC redirect (including one held across a memory stall), stall counter and memory watchdog.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.master hz
);
  localparam logic [1:0] CTRL_DEFAULT = 2'b00;
  localparam logic [1:0] CTRL_BUBBLE  = 2'b01;
  localparam logic [1:0] CTRL_STALLED = 2'b10;

  localparam int              WD_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT - 1);

  logic             pend_vld_q, pend_vld_d;
  logic [63:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;

  logic [1:0]  ctrl_if_id, ctrl_id_ex, ctrl_ex_mem, ctrl_mem_wb;
  logic        pc_wen, pc_redirect;
  logic [63:0] pc_target;
  logic        any_stall;

  always_comb begin
    ctrl_if_id  = CTRL_DEFAULT;
    ctrl_id_ex  = CTRL_DEFAULT;
    ctrl_ex_mem = CTRL_DEFAULT;
    ctrl_mem_wb = CTRL_DEFAULT;
    pc_wen      = 1'b1;
    pc_redirect = 1'b0;
    pc_target   = 64'd0;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;

    if (hz.mem_busy_i) begin
      ctrl_if_id  = CTRL_STALLED;
      ctrl_id_ex  = CTRL_STALLED;
      ctrl_ex_mem = CTRL_STALLED;
      ctrl_mem_wb = CTRL_BUBBLE;
      pc_wen      = 1'b0;
      // EX is frozen, so only the first redirect of a stall can be genuine.
      if (hz.redirect_i && !pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = hz.redirect_pc_i;
      end
    end else if (pend_vld_q) begin
      pc_redirect = 1'b1;
      pc_target   = pend_pc_q;
      ctrl_if_id  = CTRL_BUBBLE;
      ctrl_id_ex  = CTRL_BUBBLE;
      pend_vld_d  = 1'b0;
    end else if (hz.ex_busy_i) begin
      ctrl_if_id  = CTRL_STALLED;
      ctrl_id_ex  = CTRL_STALLED;
      ctrl_ex_mem = CTRL_BUBBLE;
      pc_wen      = 1'b0;
    end else if (hz.redirect_i) begin
      // The squashed younger instruction makes any load-use hazard moot.
      pc_redirect = 1'b1;
      pc_target   = hz.redirect_pc_i;
      ctrl_if_id  = CTRL_BUBBLE;
      ctrl_id_ex  = CTRL_BUBBLE;
    end else if (hz.ld_use_i) begin
      ctrl_if_id  = CTRL_STALLED;
      ctrl_id_ex  = CTRL_BUBBLE;
      pc_wen      = 1'b0;
    end

    if (!rst) begin
      ctrl_if_id  = CTRL_BUBBLE;
      ctrl_id_ex  = CTRL_BUBBLE;
      ctrl_ex_mem = CTRL_BUBBLE;
      ctrl_mem_wb = CTRL_BUBBLE;
      pc_wen      = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = 64'd0;
    end
  end

  always_comb begin
    any_stall = (ctrl_if_id == CTRL_STALLED) || (ctrl_id_ex == CTRL_STALLED) ||
                (ctrl_ex_mem == CTRL_STALLED) || (ctrl_mem_wb == CTRL_STALLED);
    stall_cnt_d = stall_cnt_q;
    if (any_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    wd_cnt_d  = '0;
    timeout_d = timeout_q;
    if (hz.mem_busy_i) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_MAX) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q  <= 1'b0;
      pend_pc_q   <= 64'd0;
      stall_cnt_q <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hz.ctrl_if_id_o  = ctrl_if_id;
  assign hz.ctrl_id_ex_o  = ctrl_id_ex;
  assign hz.ctrl_ex_mem_o = ctrl_ex_mem;
  assign hz.ctrl_mem_wb_o = ctrl_mem_wb;
  assign hz.pc_wen_o      = pc_wen;
  assign hz.pc_redirect_o = pc_redirect;
  assign hz.pc_target_o   = pc_target;
  assign hz.stall_cnt_o   = stall_cnt_q;
  assign hz.timeout_o     = timeout_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle expectations are queued as inputs are driven,
// then popped and compared against the combinational outputs before the next rising edge.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic        wen;
    logic        red;
    logic [63:0] tgt;
    logic [31:0] sc;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [31:0] sc_model = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check_val("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    n_txn++;
    $display("txn %0d ctrl=%b wen=%b red=%b tgt=%h sc=%0d to=%b", n_txn,
             {hz.ctrl_if_id_o, hz.ctrl_id_ex_o, hz.ctrl_ex_mem_o, hz.ctrl_mem_wb_o},
             hz.pc_wen_o, hz.pc_redirect_o, hz.pc_target_o, hz.stall_cnt_o, hz.timeout_o);
    check_val("ctrl", {56'd0, hz.ctrl_if_id_o, hz.ctrl_id_ex_o, hz.ctrl_ex_mem_o, hz.ctrl_mem_wb_o},
              {56'd0, e.ctrl});
    check_val("pc_wen", {63'd0, hz.pc_wen_o}, {63'd0, e.wen});
    check_val("pc_redirect", {63'd0, hz.pc_redirect_o}, {63'd0, e.red});
    check_val("pc_target", hz.pc_target_o, e.tgt);
    check_val("stall_cnt", {32'd0, hz.stall_cnt_o}, {32'd0, e.sc});
    check_val("timeout", {63'd0, hz.timeout_o}, {63'd0, e.to});
  endtask

  task automatic set_inputs(input logic ld, input logic exb, input logic red,
                            input logic [63:0] rpc, input logic mb);
    hz.ld_use_i      = ld;
    hz.ex_busy_i     = exb;
    hz.redirect_i    = red;
    hz.redirect_pc_i = rpc;
    hz.mem_busy_i    = mb;
  endtask

  task automatic cycle(input logic ld, input logic exb, input logic red, input logic [63:0] rpc,
                       input logic mb, input logic [7:0] ectrl, input logic ewen, input logic ered,
                       input logic [63:0] etgt, input logic eto);
    exp_t e;
    @(negedge clk);
    set_inputs(ld, exb, red, rpc, mb);
    e = '{ctrl: ectrl, wen: ewen, red: ered, tgt: etgt, sc: sc_model, to: eto};
    sb.push_back(e);
    #1;
    compare_front();
    if (ectrl[7:6] == 2'b10 || ectrl[5:4] == 2'b10 || ectrl[3:2] == 2'b10 || ectrl[1:0] == 2'b10)
      sc_model++;
  endtask

  task automatic expect_reset();
    exp_t e;
    e = '{ctrl: 8'b01010101, wen: 1'b0, red: 1'b0, tgt: 64'd0, sc: 32'd0, to: 1'b0};
    sb.push_back(e);
    #1;
    compare_front();
  endtask

  localparam logic [7:0] C_IDLE  = 8'b00_00_00_00;
  localparam logic [7:0] C_LDU   = 8'b10_01_00_00;
  localparam logic [7:0] C_REDIR = 8'b01_01_00_00;
  localparam logic [7:0] C_MEM   = 8'b10_10_10_01;
  localparam logic [7:0] C_EXB   = 8'b10_10_01_00;

  initial begin
    set_inputs(0, 0, 0, 64'd0, 0);
    @(negedge clk);
    expect_reset();
    rst = 1'b1;
    sc_model = 0;

    // Idle
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);
    // Load-use, then counter shows one stall
    cycle(1, 0, 0, 64'd0, 0, C_LDU, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);
    // Redirect beats load-use
    cycle(1, 0, 1, 64'h8000_0100, 0, C_REDIR, 1, 1, 64'h8000_0100, 0);
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);
    // Redirect captured during memory stall, replayed after release
    cycle(0, 0, 1, 64'h8000_0200, 1, C_MEM, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 1, C_MEM, 0, 0, 64'd0, 0);
    cycle(0, 0, 1, 64'h8000_0999, 1, C_MEM, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 0, C_REDIR, 1, 1, 64'h8000_0200, 0);
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);
    // EX busy ignores redirect
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 64'h8000_0300, 0, C_EXB, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);
    // Watchdog: eight busy cycles, flag visible afterwards and sticky
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 64'd0, 1, C_MEM, 0, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 1);
    cycle(1, 0, 0, 64'd0, 0, C_LDU, 0, 0, 64'd0, 1);
    // Async reset mid-stall with a pending redirect
    cycle(0, 0, 1, 64'h8000_0400, 1, C_MEM, 0, 0, 64'd0, 1);
    @(negedge clk);
    #3;
    rst = 1'b0;
    sc_model = 0;
    expect_reset();
    @(negedge clk);
    set_inputs(0, 0, 0, 64'd0, 0);
    rst = 1'b1;
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);
    cycle(0, 0, 0, 64'd0, 0, C_IDLE, 1, 0, 64'd0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
